// File: rtl/iic_slave_core.sv
// rtl/iic_slave_core.sv - single-address I2C target with oversampled SCL/SDA, no clock stretching
module iic_slave_core #(
  parameter logic [6:0] ADDR = 7'h3D
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  // [1:0] form the synchronizer, [2] is the delayed copy used for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [6:0] shift_q;   // bit 7 of a byte is consumed directly, only the low 7 need holding
  logic       rw_q;
  logic       sda_t_q;
  logic       busy_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;
  logic [7:0] byte_in;

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // SCL must be high on both samples so an SDA change right at an SCL edge is not a condition
  assign start_det = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign byte_in   = {shift_q, sda_s};

  assign sda_o    = 1'b0;
  assign sda_t    = sda_t_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;

  // Pad synchronizers; reset to the idle-bus level so release of reset creates no edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // Protocol FSM; START/STOP override whatever bit processing the state would do
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      sda_t_q    <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_det) begin
        state_q <= S_ADDR;
        cnt_q   <= 4'd0;
        sda_t_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (stop_det) begin
        state_q <= S_IDLE;
        cnt_q   <= 4'd0;
        sda_t_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sda_t_q <= 1'b0;
          end
          S_ADDR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= byte_in[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                rw_q <= byte_in[0];
                if (byte_in[7:1] != ADDR) begin
                  state_q <= S_WAIT_STOP;
                end else if (byte_in[0]) begin
                  // give the user the whole ACK clock to present the first read byte
                  tx_req_q <= 1'b1;
                end
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              sda_t_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                shift_q <= tx_data[6:0];
                sda_t_q <= ~tx_data[7];
                state_q <= S_TX;
              end else begin
                sda_t_q <= 1'b0;
                state_q <= S_RX;
              end
            end
          end
          S_RX: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= byte_in[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                rx_data_q  <= byte_in;
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              sda_t_q <= 1'b1;
              state_q <= S_RX_ACK;
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              sda_t_q <= 1'b0;
              cnt_q   <= 4'd0;
              state_q <= S_RX;
            end
          end
          S_TX: begin
            if (scl_rise && cnt_q != 4'd8) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_t_q <= 1'b0;
                cnt_q   <= 4'd0;
                state_q <= S_TX_ACK;
              end else begin
                sda_t_q <= ~shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
              end
            end
          end
          S_TX_ACK: begin
            // cnt_q == 1 marks that the master acknowledged and another byte is owed
            if (scl_rise) begin
              if (!sda_s) begin
                tx_req_q <= 1'b1;
                cnt_q    <= 4'd1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_WAIT_STOP;
              end
            end else if (scl_fall && cnt_q == 4'd1) begin
              shift_q <= tx_data[6:0];
              sda_t_q <= ~tx_data[7];
              cnt_q   <= 4'd0;
              state_q <= S_TX;
            end
          end
          S_WAIT_STOP: begin
            sda_t_q <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            sda_t_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_core.sv
// tb/tb_iic_slave_core.sv - self-checking bench for iic_slave_core with an I2C master model
module tb_iic_slave_core;

  localparam logic [6:0] OWN = 7'h3D;

  logic       clock;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic [7:0] tx_data;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  wire        sda_bus = sda_m & ~sda_t;

  int checks = 0;
  int failures = 0;

  // transaction-level model of the target
  bit         m_addressed = 0;
  bit         m_rw = 0;
  int         exp_txreq = 0;
  int         got_txreq = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];

  iic_slave_core #(.ADDR(OWN)) dut (
    .clock(clock), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // user side: hand out the next read byte whenever the core asks
  initial forever begin
    @(negedge clock);
    if (!reset && tx_req && tx_src.size() > 0) tx_data = tx_src.pop_front();
  end

  // per-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("sda_o_const", sda_o, 0);
      if (!m_addressed) begin
        chk("sda_t_unaddressed", sda_t, 0);
        chk("busy_unaddressed", busy, 0);
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_valid_unexpected", rx_valid, 0);
        else chk("rx_data_stream", rx_data, exp_rx.pop_front());
      end
      if (tx_req) got_txreq++;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic send_bit(input bit b);
    clk_wait(4); sda_m = b; clk_wait(4); scl_m = 1; clk_wait(8); scl_m = 0;
  endtask

  task automatic recv_bit(output bit b);
    clk_wait(4); sda_m = 1; clk_wait(4); scl_m = 1; clk_wait(4); b = sda_bus; clk_wait(4); scl_m = 0;
  endtask

  task automatic bus_start();
    if (scl_m == 0) begin
      clk_wait(4); sda_m = 1; clk_wait(4); scl_m = 1;
    end
    clk_wait(8); sda_m = 0; clk_wait(8); scl_m = 0;
    m_addressed = 0;
  endtask

  task automatic bus_stop();
    clk_wait(4); sda_m = 0; clk_wait(4); scl_m = 1; clk_wait(8); sda_m = 1; clk_wait(8);
    m_addressed = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit exp_ack, input string nm);
    bit a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    chk(nm, a, exp_ack ? 0 : 1);
  endtask

  task automatic addr_byte(input logic [7:0] v);
    bit match;
    match = (v[7:1] == OWN);
    if (match) begin
      m_addressed = 1;
      m_rw = v[0];
      if (v[0]) exp_txreq++;
    end
    send_byte(v, match, "addr_ack");
    chk("busy_after_addr", busy, match);
  endtask

  task automatic wr_byte(input logic [7:0] v);
    bit acc;
    acc = m_addressed && !m_rw;
    if (acc) exp_rx.push_back(v);
    send_byte(v, acc, "data_ack");
  endtask

  task automatic rd_byte(input logic [7:0] exp_v, input bit master_ack);
    bit b;
    logic [7:0] r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      r[i] = b;
    end
    chk("read_byte", r, exp_v);
    if (master_ack) exp_txreq++;
    send_bit(master_ack ? 1'b0 : 1'b1);
    if (!master_ack) begin
      m_addressed = 0;
      clk_wait(2);
      chk("busy_after_nack", busy, 0);
      chk("sda_released_after_nack", sda_t, 0);
    end
  endtask

  task automatic end_scen();
    clk_wait(4);
    chk("rx_pending", exp_rx.size(), 0);
    chk("tx_req_count", got_txreq, exp_txreq);
  endtask

  initial begin
    bit b;
    reset = 1; scl_m = 1; sda_m = 1; tx_data = 8'h00;
    clk_wait(4);
    @(negedge clock) reset = 0;
    clk_wait(4);
    chk("rst_sda_t", sda_t, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);

    // write to own address
    bus_start(); addr_byte(8'h7A); wr_byte(8'hA5);
    chk("busy_mid_write", busy, 1);
    bus_stop();
    chk("write_rx_data", rx_data, 8'hA5);
    chk("busy_after_stop", busy, 0);
    end_scen();

    // wrong address
    bus_start(); addr_byte(8'h78); wr_byte(8'h55); bus_stop();
    chk("wrong_rx_data_kept", rx_data, 8'hA5);
    end_scen();

    // read two bytes, then show the bus is ignored until a condition
    tx_src.push_back(8'h5A); tx_src.push_back(8'hC3);
    bus_start(); addr_byte(8'h7B);
    rd_byte(8'h5A, 1);
    rd_byte(8'hC3, 0);
    send_byte(8'h7A, 0, "wait_stop_ignores");
    bus_stop();
    end_scen();
    chk("read_tx_req_total", got_txreq, 2);

    // repeated START with direction change
    tx_src.push_back(8'h96);
    bus_start(); addr_byte(8'h7A); wr_byte(8'h10);
    bus_start(); addr_byte(8'h7B);
    rd_byte(8'h96, 0);
    bus_stop();
    chk("rs_rx_data", rx_data, 8'h10);
    end_scen();
    chk("rs_tx_req_total", got_txreq, 3);

    // reset during bit 4 of a read
    tx_src.push_back(8'h00);
    bus_start(); addr_byte(8'h7B);
    for (int i = 0; i < 3; i++) recv_bit(b);
    clk_wait(4); sda_m = 1; clk_wait(4); scl_m = 1; clk_wait(4);
    chk("pre_reset_driving", sda_t, 1);
    reset = 1;
    m_addressed = 0;
    #1;
    chk("reset_sda_t_async", sda_t, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_req", tx_req, 0);
    clk_wait(3);
    @(negedge clock) reset = 0;
    got_txreq = exp_txreq;
    clk_wait(4); scl_m = 0; clk_wait(8); scl_m = 1; clk_wait(8);

    // STOP in the middle of a write byte, then a clean write
    bus_start(); addr_byte(8'h7A);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    chk("abort_busy", busy, 0);
    chk("abort_rx_data", rx_data, 8'h00);
    bus_start(); addr_byte(8'h7A); wr_byte(8'h33); bus_stop();
    chk("after_abort_rx_data", rx_data, 8'h33);
    end_scen();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iic_slave_core.md
# iic_slave_core

Single-address I2C target (slave) that sits opposite `iic_core` on the same bus. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address. Written bytes go out on a one-cycle strobe; read bytes are pulled from the user through a request strobe. SDA is open-drain through the same `sda_i`/`sda_o`/`sda_t` IOBUF arrangement the master uses; SCL is input-only, with no clock stretching.

## Interface
- `ADDR`, default 7'h3D: own 7-bit address. A write address byte of 0x7A matches; 0x7B is a read.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  SCL pad input, asynchronous.
- `sda_i`  in  1  SDA pad input, asynchronous.
- `sda_o`  out 1  SDA output value; tied constant 0.
- `sda_t`  out 1  SDA drive enable; 1 pulls SDA low, 0 releases it.
- `rx_data` out 8  last byte received from the master.
- `rx_valid` out 1  one-cycle strobe; `rx_data` is new.
- `tx_data` in  8  byte to return on a read. Must be stable from `tx_req` until the next SCL fall.
- `tx_req`  out 1  one-cycle strobe; the core needs `tx_data` at the next SCL fall.
- `busy`   out 1  high while this target is addressed.

## Operation
- **Input sync:** `scl_i` and `sda_i` each pass through a 2-FF synchronizer, then a delay register for edge detection.
  - `scl_rise`/`scl_fall`: synchronized SCL changed 0→1 or 1→0.
  - START: synchronized SDA falls while synchronized SCL is high. STOP: SDA rises while SCL is high.
- **Priority:** START/STOP beat bit processing in the same cycle.
  - START in any state → ADDR, bit counter cleared, `sda_t`=0.
  - STOP in any state → IDLE, `sda_t`=0, `busy`=0.
- **Data rules:** data is sampled on `scl_rise`, MSB first. `sda_t` changes only on `scl_fall`, START, STOP, or reset.
- **Bit counter:** 4 bits, 0..8, cleared on entry to every byte state.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th `scl_rise`, compare `shift[7:1]` with `ADDR` and latch `rw` = `shift[0]`.
    - Match: at the next `scl_fall`, `sda_t`=1, `busy`=1 → ADDR_ACK. If `rw`=1, also pulse `tx_req` on the compare cycle.
    - Mismatch: → WAIT_STOP, never drive.
  - ADDR_ACK: at `scl_fall` ending the ACK clock:
    - `rw`=0: `sda_t`=0 → RX.
    - `rw`=1: load `tx_data` into the shift register, `sda_t`=~`tx_data[7]` → TX.
  - RX: shift 8 bits. On the 8th `scl_rise`, `rx_data` ← byte and `rx_valid` pulses on the following cycle. Next `scl_fall`: `sda_t`=1 (always ACK) → RX_ACK.
  - RX_ACK: at `scl_fall`, `sda_t`=0 → RX.
  - TX: at each `scl_fall`, present the next bit with `sda_t`=~bit. At the `scl_fall` after the 8th bit, `sda_t`=0 → TX_ACK.
  - TX_ACK: at `scl_rise`, sample SDA.
    - 0 (ACK): pulse `tx_req`; at the next `scl_fall`, load `tx_data` and drive its bit 7 → TX.
    - 1 (NACK): → WAIT_STOP.
  - WAIT_STOP: bus ignored, `sda_t`=0, `busy`=0; leave only on START or STOP.
- **Repeated START:** behaves like START. `busy` drops until the next address match.
- **Overruns:** `rx_valid` is not back-pressured. An unread `rx_data` is overwritten by the next byte.

## Timing
- **Reset values:** `sda_t`=0, `sda_o`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state IDLE. Reset may assert mid-byte; SDA is released in the same cycle, asynchronously.
- **Input latency:** pad to `scl_rise`/START detect is 3 clocks.
- **ACK drive:** `sda_t` changes 1 clock after `scl_fall` detection, i.e. 4 clocks after the pad edge.
- **`rx_valid`:** exactly 1 cycle, 1 clock after the 8th-bit `scl_rise`.
- **`tx_req`:** exactly 1 cycle. The user has until `scl_fall` (≥ SCL high time) to present `tx_data`.
- **Clock requirement:** SCL high and low phases ≥ 6 clocks each, e.g. 100 MHz clock covers 400 kHz SCL with margin. SDA must be stable ≥ 4 clocks around SCL edges, per I2C hold time.

## Test plan
- **Write to own address:** START, 0x7A, 0xA5, STOP. Expect `sda_t`=1 during the 9th SCL clock of both bytes, `rx_data`=0xA5 with one `rx_valid` pulse, `busy` 1 from address match to STOP, then 0.
- **Wrong address:** START, 0x78, 0x55, STOP. Expect `sda_t` never 1, no `rx_valid`, `busy`=0 throughout, IDLE after STOP.
- **Read two bytes:** START, 0x7B; user returns 0x5A then 0xC3; master ACKs the first, NACKs the second. Expect bits 01011010 then 11000011 on SDA, two `tx_req` pulses, SDA released after the NACK, then WAIT_STOP.
- **Repeated START:** START, 0x7A, 0x10, repeated START, 0x7B, read one byte (NACK), STOP. Expect `rx_data`=0x10, a direction change with one `tx_req` per acknowledged position, IDLE at STOP.
- **Aborts:**
  - Assert `reset` during bit 4 of a read. Expect `sda_t`=0 immediately and all outputs at reset values.
  - In a separate run, issue STOP mid-write-byte. Expect no `rx_valid`, IDLE, and the next START, 0x7A, 0x33 received correctly.
